hazard_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage pipeline. It generates write-enable, flush and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards, flushes wrong-path instructions on taken branches and jumps resolved in EX, and freezes the pipeline while a data-memory access awaits its ready handshake. It sits beside the pipeline registers and drives only their control inputs.

---
 rtl/hazard_stall_ctrl_if.sv | 14 +
 rtl/hazard_stall_ctrl.sv | 60 ++++++
 tb/tb_hazard_stall_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: hazard/handshake inputs from the pipeline and the register controls returned to it
interface hazard_stall_ctrl_if;
  logic [4:0] ID_rs, ID_rt, EX_rt;
  logic       ID_UsesRs, ID_UsesRt, EX_MemRead, EX_BranchTaken, EX_Jump, MEM_Req, MEM_Ready;
  logic       PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write, MEMWB_Bubble;
  modport master (
    output ID_rs, ID_rt, EX_rt, ID_UsesRs, ID_UsesRt, EX_MemRead, EX_BranchTaken, EX_Jump, MEM_Req, MEM_Ready,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write, MEMWB_Bubble
  );
  modport slave (
    input  ID_rs, ID_rt, EX_rt, ID_UsesRs, ID_UsesRt, EX_MemRead, EX_BranchTaken, EX_Jump, MEM_Req, MEM_Ready,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write, MEMWB_Bubble
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: freeze/redirect/load-use sequencing for the five-stage pipeline.
// Define HAZARD_STATS_EN to build the Stall_Cnt/Flush_Cnt statistics counters.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_stall_ctrl_if.slave  hz,
  output logic                MEM_Timeout,
  output logic [15:0]         Stall_Cnt,
  output logic [15:0]         Flush_Cnt
);
  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       freeze, load_use, redirect, pc_write, ifid_flush, idex_flush;
  assign freeze   = hz.MEM_Req & ~hz.MEM_Ready;
  assign redirect = hz.EX_BranchTaken | hz.EX_Jump;
  assign load_use = hz.EX_MemRead & (hz.EX_rt != 5'd0) &
                    ((hz.ID_UsesRs & (hz.ID_rs == hz.EX_rt)) | (hz.ID_UsesRt & (hz.ID_rt == hz.EX_rt)));
  // Priority freeze > redirect > load_use falls out of the masking below
  assign pc_write        = ~freeze & (redirect | ~load_use);
  assign ifid_flush      = ~freeze & redirect;
  assign idex_flush      = ~freeze & (redirect | load_use);
  assign hz.PC_Write     = pc_write;
  assign hz.IFID_Write   = pc_write;
  assign hz.IFID_Flush   = ifid_flush;
  assign hz.IDEX_Write   = ~freeze;
  assign hz.IDEX_Flush   = idex_flush;
  assign hz.EXMEM_Write  = ~freeze;
  assign hz.MEMWB_Bubble = freeze;
  always_comb begin
    state_nxt    = (state == RUN) ? (freeze ? MEM_WAIT : RUN) : (hz.MEM_Ready ? RUN : MEM_WAIT);
    wait_cnt_nxt = (state == RUN) ? 8'd0 : ((hz.MEM_Ready || &wait_cnt) ? wait_cnt : wait_cnt + 8'd1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      MEM_Timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      MEM_Timeout <= MEM_Timeout | ((wait_cnt_nxt == TMO) && (wait_cnt_nxt != wait_cnt));
    end
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      Stall_Cnt <= 16'd0;
      Flush_Cnt <= 16'd0;
    end else begin
      Stall_Cnt <= (!pc_write && !(&Stall_Cnt)) ? Stall_Cnt + 16'd1 : Stall_Cnt;
      Flush_Cnt <= ((ifid_flush || idex_flush) && !(&Flush_Cnt)) ? Flush_Cnt + 16'd1 : Flush_Cnt;
    end
`else
  assign Stall_Cnt = 16'd0;
  assign Flush_Cnt = 16'd0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed test-plan sequences plus random stimulus against a priority-table model
module tb_hazard_stall_ctrl;
  localparam int TMO = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic MEM_Timeout;
  logic [15:0] Stall_Cnt, Flush_Cnt;
  int total = 0, bad = 0;
  int exp_stall = 0, exp_flush = 0, frz_run = 0;
  bit exp_tmo = 1'b0;
  hazard_stall_ctrl_if hz ();
  hazard_stall_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz.slave),
    .MEM_Timeout(MEM_Timeout), .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write, MEMWB_Bubble}
  function automatic logic [6:0] ref_ctrl();
    bit f, rd, lu;
    f  = hz.MEM_Req && !hz.MEM_Ready;
    rd = hz.EX_BranchTaken || hz.EX_Jump;
    lu = hz.EX_MemRead && hz.EX_rt != 0 &&
         ((hz.ID_UsesRs && hz.ID_rs == hz.EX_rt) || (hz.ID_UsesRt && hz.ID_rt == hz.EX_rt));
    if (f)  return 7'b0000001;
    if (rd) return 7'b1111110;
    if (lu) return 7'b0001110;
    return 7'b1101010;
  endfunction
  task automatic drive(input logic [4:0] rs, rt, ert, input bit urs, urt, mr, bt, jp, rq, rdy);
    hz.ID_rs = rs; hz.ID_rt = rt; hz.EX_rt = ert;
    hz.ID_UsesRs = urs; hz.ID_UsesRt = urt; hz.EX_MemRead = mr;
    hz.EX_BranchTaken = bt; hz.EX_Jump = jp; hz.MEM_Req = rq; hz.MEM_Ready = rdy;
  endtask
  task automatic check_regs();
    check("timeout", MEM_Timeout, exp_tmo);
`ifdef HAZARD_STATS_EN
    check("stall_cnt", Stall_Cnt, exp_stall);
    check("flush_cnt", Flush_Cnt, exp_flush);
`else
    check("stall_cnt", Stall_Cnt, 0);
    check("flush_cnt", Flush_Cnt, 0);
`endif
  endtask
  // One pipeline cycle: check combinational controls mid-cycle, then registered state after the edge
  task automatic tick();
    logic [6:0] e;
    @(negedge clk);
    e = ref_ctrl();
    check("ctrl", {hz.PC_Write, hz.IFID_Write, hz.IFID_Flush, hz.IDEX_Write, hz.IDEX_Flush,
                   hz.EXMEM_Write, hz.MEMWB_Bubble}, e);
    if (!e[6] && exp_stall < 16'hFFFF) exp_stall++;
    if ((e[4] || e[2]) && exp_flush < 16'hFFFF) exp_flush++;
    frz_run = (hz.MEM_Req && !hz.MEM_Ready) ? frz_run + 1 : 0;
    // the entry cycle is spent in RUN, so the wait count lags the freeze run by one
    if (frz_run == TMO + 1) exp_tmo = 1'b1;
    @(posedge clk);
    #1;
    check_regs();
  endtask
  task automatic model_reset();
    exp_stall = 0; exp_flush = 0; frz_run = 0; exp_tmo = 1'b0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    drive(5, 0, 5, 1, 0, 1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc_write", hz.PC_Write, 0);
    check_regs();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // load-use stall, then released, then EX_rt=0 never stalls
    drive(5, 0, 5, 1, 0, 1, 0, 0, 0, 0); tick();
    drive(5, 0, 5, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 1, 1, 0, 0, 0, 0); tick();
    drive(3, 5, 5, 0, 1, 1, 0, 0, 0, 0); tick();
    // taken branch overrides a load-use
    drive(5, 0, 5, 1, 0, 1, 1, 0, 0, 0); tick();
    // memory wait of 3 cycles
    repeat (3) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick(); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    // jump held through a 2-cycle freeze
    repeat (2) begin drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); tick(); end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 1); tick();
    // timeout and its stickiness
    repeat (TMO + 2) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick(); end
    check("timeout_set", MEM_Timeout, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    repeat (2) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); end
    // asynchronous reset at wait count 2
    repeat (3) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick(); end
    check("wait_cnt_pre", dut.wait_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_wait_cnt", dut.wait_cnt, 0);
    check_regs();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // a full TMO-cycle wait right after reset must not time out yet
    repeat (TMO) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick(); end
    check("no_early_timeout", MEM_Timeout, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    // random traffic; a freeze once started is held until MEM_Ready
    repeat (3000) begin
      hz.ID_rs = 5'($urandom_range(0, 3));
      hz.ID_rt = 5'($urandom_range(0, 3));
      hz.EX_rt = 5'($urandom_range(0, 3));
      hz.ID_UsesRs = 1'($urandom);
      hz.ID_UsesRt = 1'($urandom);
      hz.EX_MemRead = 1'($urandom);
      hz.EX_BranchTaken = ($urandom_range(0, 5) == 0);
      hz.EX_Jump = ($urandom_range(0, 7) == 0);
      hz.MEM_Req = (frz_run > 0) ? 1'b1 : 1'($urandom);
      hz.MEM_Ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
